mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Consumer side of the EX/MEM pipeline register: takes the MEM-stage control and data fields, runs the data-memory request/ready handshake, stalls the upstream pipeline while an access is outstanding, and loads the MEM/WB register with the selected write-back value. Sits between the EX/MEM register outputs and the write-back stage. It is the only block that drives the data-memory bus.

## Interface
Parameters:
- AW, 32, data-memory address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- mem_read_i  in  1  EX/MEM MemRead
- mem_write_i  in  1  EX/MEM MemWrite
- mem_to_reg_i  in  2  write-back select: 0 ALU, 1 memory, 2 PC+4, 3 reserved (treated as ALU)
- reg_write_i  in  1  EX/MEM RegWrite
- alu_out_i  in  DW  address / ALU result
- mem_wdata_i  in  DW  store data
- reg_waddr_i  in  5  destination register
- pc_plus4_i, pc_i  in  DW  instruction PC+4 and PC
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  AW  word-aligned byte address
- dmem_wdata  out  DW  store data
- dmem_ready  in  1  access complete (read data valid this cycle)
- dmem_rdata  in  DW  read data
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- reg_write_wb  out  1  MEM/WB RegWrite
- reg_waddr_wb  out  5  MEM/WB destination
- wb_data  out  DW  MEM/WB write-back value
- stall_cycles  out  32  saturating count of stalled cycles
- addr_exc, exc_pc  out  1, DW  misalignment exception (only with MEM_ALIGN_CHECK_EN)

## Operation
- access = mem_read_i | mem_write_i; mem_write_i wins if both set (read ignored, dmem_we=1).
- FSM states: IDLE, WAIT.
  - IDLE, no access: no request; WB register loads inputs; stall=0.
  - IDLE, access: dmem_req=1 combinationally. If dmem_ready same cycle: complete, stay IDLE, stall=0. Else stall=1, go WAIT.
  - WAIT: dmem_req=1, stall=1 until dmem_ready; on ready cycle stall=0, complete, go IDLE.
- dmem_addr = alu_out_i, dmem_wdata = mem_wdata_i, dmem_we = mem_write_i; stable during WAIT because EX/MEM is frozen.
- On completion (and on non-access cycles) WB register loads reg_write_i, reg_waddr_i, and wb_data per mem_to_reg_i (memory select uses dmem_rdata).
- Every stalled cycle loads a bubble into WB: reg_write_wb=0, reg_waddr_wb=0, wb_data held.
- stall_cycles increments on each clock edge with stall=1; saturates at 0xFFFF_FFFF.

## Timing
- Reset values: state IDLE, reg_write_wb 0, reg_waddr_wb 0, wb_data 0, stall_cycles 0, addr_exc 0, exc_pc 0. dmem_req, stall combinational and 0 during reset.
- Zero-wait access or non-access: WB outputs valid 1 cycle after MEM inputs.
- N-cycle memory (ready N cycles after first request): stall high N cycles, WB valid N+1 edges after entry.
- Reset mid-WAIT: dmem_req and stall drop immediately; outstanding access abandoned; memory must ignore a late dmem_ready.
- dmem_ready while dmem_req=0: ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined: access with alu_out_i[1:0]!=0 issues no request, no stall; next edge sets addr_exc=1 for one cycle, exc_pc=pc_i, reg_write_wb=0. Non-access instructions unchecked.
- Undefined: addr_exc tied 0, exc_pc tied 0; dmem_addr forced to {alu_out_i[AW-1:2],2'b00}.

## Structure
- Shared package mips_pipe_pkg: WB_SEL_ALU/WB_SEL_MEM/WB_SEL_PC4 encodings, mem_state_t (IDLE, WAIT).
- Sub-module mem_wb_reg: the MEM/WB register with load and bubble inputs and async reset; FSM, mux, and counter stay in mem_stage_ctrl.

## Test plan
- Load, ready same cycle, alu_out=0x100, rdata=0xDEADBEEF, mem_to_reg=1, waddr=8 -> no stall; next edge reg_write_wb=1, reg_waddr_wb=8, wb_data=0xDEADBEEF.
- Store with ready after 3 cycles, addr 0x40, wdata 0x1234 -> dmem_req/we high 4 cycles, stall high 3, stall_cycles=3, reg_write_wb=0 throughout.
- ALU op then jal (mem_to_reg=2, pc_plus4=0x404) back-to-back -> wb_data 0x(alu) then 0x404, no stall.
- Reset asserted during WAIT -> dmem_req, stall 0 immediately; all WB outputs 0; late ready causes no WB load.
- With MEM_ALIGN_CHECK_EN, load at 0x103, pc 0x200 -> dmem_req never high; addr_exc=1 one cycle, exc_pc=0x200, reg_write_wb=0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline encodings: write-back select codes and MEM-stage FSM states.
package mips_pipe_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears RegWrite/destination and holds the data;
// otherwise load captures the new write-back fields.
module mem_wb_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          bubble,
  input  logic          reg_write_i,
  input  logic [4:0]    reg_waddr_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          reg_write_o,
  output logic [4:0]    reg_waddr_o,
  output logic [DW-1:0] wb_data_o
);

  logic          reg_write_d, reg_write_q;
  logic [4:0]    reg_waddr_d, reg_waddr_q;
  logic [DW-1:0] wb_data_d,   wb_data_q;

  always_comb begin
    reg_write_d = reg_write_q;
    reg_waddr_d = reg_waddr_q;
    wb_data_d   = wb_data_q;
    if (bubble) begin
      reg_write_d = 1'b0;
      reg_waddr_d = 5'd0;
    end else if (load) begin
      reg_write_d = reg_write_i;
      reg_waddr_d = reg_waddr_i;
      wb_data_d   = wb_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      reg_waddr_q <= 5'd0;
      wb_data_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      reg_waddr_q <= reg_waddr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign reg_write_o = reg_write_q;
  assign reg_waddr_o = reg_waddr_q;
  assign wb_data_o   = wb_data_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: data-memory handshake, upstream stall, MEM/WB load, stall counter.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses raise addr_exc instead of reaching memory.
module mem_stage_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic [1:0]    mem_to_reg_i,
  input  logic          reg_write_i,
  input  logic [DW-1:0] alu_out_i,
  input  logic [DW-1:0] mem_wdata_i,
  input  logic [4:0]    reg_waddr_i,
  input  logic [DW-1:0] pc_plus4_i,
  input  logic [DW-1:0] pc_i,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ready,
  input  logic [DW-1:0] dmem_rdata,
  output logic          stall,
  output logic          reg_write_wb,
  output logic [4:0]    reg_waddr_wb,
  output logic [DW-1:0] wb_data,
  output logic [31:0]   stall_cycles,
  output logic          addr_exc,
  output logic [DW-1:0] exc_pc
);

  mem_state_t    state_q, state_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;
  logic          access, misalign;
  logic [DW-1:0] wb_sel_data;

  always_comb begin
    access = mem_read_i | mem_write_i;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = access & (alu_out_i[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    // Gated by reset so an abandoned access releases the bus and pipeline at once.
    dmem_req = ~reset & ((state_q == WAIT) | (access & ~misalign));
    stall    = dmem_req & ~dmem_ready;
    state_d  = stall ? WAIT : IDLE;

    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;

    case (mem_to_reg_i)
      WB_SEL_MEM: wb_sel_data = dmem_rdata;
      WB_SEL_PC4: wb_sel_data = pc_plus4_i;
      default:    wb_sel_data = alu_out_i;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign dmem_we      = mem_write_i;
  assign dmem_wdata   = mem_wdata_i;
  assign stall_cycles = stall_cycles_q;

  mem_wb_reg #(.DW(DW)) u_mem_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (~stall),
    .bubble      (stall | misalign),
    .reg_write_i (reg_write_i),
    .reg_waddr_i (reg_waddr_i),
    .wb_data_i   (wb_sel_data),
    .reg_write_o (reg_write_wb),
    .reg_waddr_o (reg_waddr_wb),
    .wb_data_o   (wb_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic          addr_exc_d, addr_exc_q;
  logic [DW-1:0] exc_pc_d,   exc_pc_q;

  always_comb begin
    addr_exc_d = misalign;
    exc_pc_d   = misalign ? pc_i : exc_pc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_exc_q <= 1'b0;
      exc_pc_q   <= '0;
    end else begin
      addr_exc_q <= addr_exc_d;
      exc_pc_q   <= exc_pc_d;
    end
  end

  assign dmem_addr = alu_out_i[AW-1:0];
  assign addr_exc  = addr_exc_q;
  assign exc_pc    = exc_pc_q;
`else
  logic unused_pc;
  assign unused_pc = ^{pc_i, alu_out_i[1:0]};

  assign dmem_addr = {alu_out_i[AW-1:2], 2'b00};
  assign addr_exc  = 1'b0;
  assign exc_pc    = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: the driver pushes per-cycle MEM/WB expectations
// derived from instruction-level rules; a monitor pops and compares after each edge.
module tb_mem_stage_ctrl;

  logic        clk, reset;
  logic        mem_read_i, mem_write_i, reg_write_i;
  logic [1:0]  mem_to_reg_i;
  logic [31:0] alu_out_i, mem_wdata_i, pc_plus4_i, pc_i;
  logic [4:0]  reg_waddr_i;
  logic        dmem_req, dmem_we, dmem_ready, stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        reg_write_wb, addr_exc;
  logic [4:0]  reg_waddr_wb;
  logic [31:0] wb_data, stall_cycles, exc_pc;

  mem_stage_ctrl #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .reg_write_i(reg_write_i), .alu_out_i(alu_out_i), .mem_wdata_i(mem_wdata_i),
    .reg_waddr_i(reg_waddr_i), .pc_plus4_i(pc_plus4_i), .pc_i(pc_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall),
    .reg_write_wb(reg_write_wb), .reg_waddr_wb(reg_waddr_wb), .wb_data(wb_data),
    .stall_cycles(stall_cycles), .addr_exc(addr_exc), .exc_pc(exc_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] data;
    logic [31:0] sc;
    logic        exc;
    logic [31:0] epc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 0;
  logic [31:0] exp_data = 0;
  logic [31:0] exp_sc   = 0;
  logic [31:0] exp_epc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: WB register presents a new value after every edge.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("reg_write_wb", {31'd0, reg_write_wb}, {31'd0, e.rw});
      chk("reg_waddr_wb", {27'd0, reg_waddr_wb}, {27'd0, e.wa});
      chk("wb_data", wb_data, e.data);
      chk("stall_cycles", stall_cycles, e.sc);
      chk("addr_exc", {31'd0, addr_exc}, {31'd0, e.exc});
      chk("exc_pc", exc_pc, e.epc);
    end
  end

  // One instruction held in EX/MEM until the memory completes it after lat stalled cycles.
  task automatic issue(input bit rd, input bit wr, input logic [1:0] sel, input bit rw,
                       input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc4, input logic [31:0] pc, input logic [31:0] rdat,
                       input int lat);
    bit acc, mis, mem;
    int n;
    exp_t e;
    acc = rd | wr;
    mis = 0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = acc && (alu[1:0] != 2'b00);
`endif
    mem = acc && !mis;
    n = mem ? lat : 0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      mem_read_i = rd; mem_write_i = wr; mem_to_reg_i = sel; reg_write_i = rw;
      reg_waddr_i = wa; alu_out_i = alu; mem_wdata_i = wd; pc_plus4_i = pc4; pc_i = pc;
      dmem_ready = mem ? (c == n) : 1'($urandom_range(0, 1));
      dmem_rdata = (c == n) ? rdat : $urandom;
      #1;
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, mem});
      chk("stall", {31'd0, stall}, {31'd0, (mem && c < n)});
      if (mem) begin
`ifdef MEM_ALIGN_CHECK_EN
        chk("dmem_addr", dmem_addr, alu);
`else
        chk("dmem_addr", dmem_addr, alu & 32'hFFFF_FFFC);
`endif
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, wr});
        chk("dmem_wdata", dmem_wdata, wd);
      end
      e.exc = 1'b0;
      if (c < n) begin
        e.rw = 1'b0; e.wa = 5'd0;
        if (exp_sc != 32'hFFFF_FFFF) exp_sc++;
      end else if (mis) begin
        e.rw = 1'b0; e.wa = 5'd0; e.exc = 1'b1; exp_epc = pc;
      end else begin
        e.rw = rw; e.wa = wa;
        exp_data = (sel == 2'd1) ? rdat : (sel == 2'd2) ? pc4 : alu;
      end
      e.data = exp_data; e.sc = exp_sc; e.epc = exp_epc;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_read_i = 1'b1; mem_write_i = 1'b0; mem_to_reg_i = 2'd0; reg_write_i = 1'b1;
    reg_waddr_i = 5'd3; alu_out_i = 32'h10; mem_wdata_i = 0; pc_plus4_i = 0; pc_i = 0;
    dmem_ready = 1'b0; dmem_rdata = 0;
    #2;
    chk("rst_req", {31'd0, dmem_req}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_rw", {31'd0, reg_write_wb}, 0);
    chk("rst_wa", {27'd0, reg_waddr_wb}, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_sc", stall_cycles, 0);
    chk("rst_exc", {31'd0, addr_exc}, 0);
    chk("rst_epc", exc_pc, 0);
    @(negedge clk);
    mem_read_i = 1'b0;
    reset = 1'b0;
    mon_en = 1;

    // Directed: zero-wait load, 3-cycle store, ALU then jal.
    issue(1, 0, 2'd1, 1, 5'd8, 32'h100, 0, 32'h4, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 1, 2'd0, 0, 5'd0, 32'h40, 32'h1234, 32'h8, 32'h4, 32'h0, 3);
    issue(0, 0, 2'd0, 1, 5'd9, 32'h55AA, 0, 32'hC, 32'h8, 32'h0, 0);
    issue(0, 0, 2'd2, 1, 5'd31, 32'h77, 0, 32'h404, 32'h400, 32'h0, 0);
`ifdef MEM_ALIGN_CHECK_EN
    issue(1, 0, 2'd1, 1, 5'd4, 32'h103, 0, 32'h204, 32'h200, 32'h1111, 0);
    issue(0, 0, 2'd0, 1, 5'd5, 32'h99, 0, 32'h208, 32'h204, 32'h0, 0);
`endif

    // Reset in the middle of an outstanding load.
    @(negedge clk);
    mon_en = 0;
    mem_read_i = 1; mem_write_i = 0; mem_to_reg_i = 2'd1; reg_write_i = 1; reg_waddr_i = 5'd7;
    alu_out_i = 32'h200; dmem_ready = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstw_req", {31'd0, dmem_req}, 0);
    chk("rstw_stall", {31'd0, stall}, 0);
    chk("rstw_rw", {31'd0, reg_write_wb}, 0);
    chk("rstw_wa", {27'd0, reg_waddr_wb}, 0);
    chk("rstw_data", wb_data, 0);
    chk("rstw_sc", stall_cycles, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_read_i = 0; mem_to_reg_i = 2'd0; reg_write_i = 0; reg_waddr_i = 0; alu_out_i = 0;
    dmem_ready = 1; dmem_rdata = 32'hBAD0BAD0;
    #1;
    chk("late_req", {31'd0, dmem_req}, 0);
    @(posedge clk);
    #2;
    chk("late_rw", {31'd0, reg_write_wb}, 0);
    chk("late_data", wb_data, 0);
    chk("late_sc", stall_cycles, 0);
    exp_data = 0; exp_sc = 0; exp_epc = 0;
    mon_en = 1;

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic [1:0] sel;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      sel  = 2'($urandom_range(0, 3));
      a    = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
`endif
      issue(kind[0], kind[1], sel, 1'($urandom_range(0, 1)), 5'($urandom),
            a, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 4));
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
